l1_dcache_dm: RTL and testbench

Parametrised direct-mapped L1 data cache sitting between the core's memory stage and data memory, replacing the fixed 64-line L1. Write-through, no-write-allocate, with a variable-latency req/ack memory port, a single-cycle valid-bit flush and saturating hit/miss counters. The core holds the current instruction stable while `stall` is high.

---
 rtl/l1_dcache_dm.sv | 232 +++++++++++++++++++++++
 tb/tb_l1_dcache_dm.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_dcache_dm.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache with one 32-bit word per line.
// Lookup is combinational in IDLE; misses and stores go through a registered req/ack memory port.
module l1_dcache_dm #(
    parameter int ADDR_W  = 10,
    parameter int INDEX_W = 6,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [6:0]        opcode_in,
    input  logic [2:0]        mask,
    input  logic [ADDR_W-1:0] address_in,
    input  logic [31:0]       data_in,
    input  logic              flush,
    output logic [31:0]       data_out,
    output logic              stall,
    output logic              misalign,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);
    localparam int TAG_W = ADDR_W - INDEX_W - 2;
    localparam int LINES = 2 ** INDEX_W;

    typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU} state_t;

    state_t              r_state, w_state_next;
    logic [LINES-1:0]    r_valid;
    logic [TAG_W-1:0]    r_tag  [LINES];
    logic [31:0]         r_line [LINES];
    logic                r_refill_done;
    logic                r_mem_req, r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [31:0]         r_mem_wdata;
    logic [3:0]          r_mem_be;
    logic [CNT_W-1:0]    r_hit_cnt, r_miss_cnt;

    logic [INDEX_W-1:0]  w_index;
    logic [TAG_W-1:0]    w_tag;
    logic [1:0]          w_off;
    logic                w_is_load, w_is_store, w_bad_size, w_hit;
    logic [31:0]         w_line, w_load_data, w_merged, w_st_wdata;
    logic [7:0]          w_byte;
    logic [15:0]         w_half;
    logic [3:0]          w_st_be;
    logic                w_start_rd, w_start_wr, w_fill, w_merge, w_done;
    logic                w_hit_inc, w_miss_inc, w_clr_refill, w_flush;

    assign w_index    = address_in[INDEX_W+1:2];
    assign w_tag      = address_in[ADDR_W-1:INDEX_W+2];
    assign w_off      = address_in[1:0];
    assign w_is_load  = (opcode_in == 7'b0000011);
    assign w_is_store = (opcode_in == 7'b0100011);
    assign w_line     = r_line[w_index];
    assign w_hit      = r_valid[w_index] && (r_tag[w_index] == w_tag);
    assign misalign   = (w_is_load || w_is_store) && w_bad_size;

    always_comb begin
        case (mask)
            3'b000, 3'b100: w_bad_size = 1'b0;
            3'b001, 3'b101: w_bad_size = w_off[0];
            3'b010:         w_bad_size = (w_off != 2'b00);
            default:        w_bad_size = 1'b1;
        endcase
    end

    always_comb begin
        case (w_off)
            2'd0:    w_byte = w_line[7:0];
            2'd1:    w_byte = w_line[15:8];
            2'd2:    w_byte = w_line[23:16];
            default: w_byte = w_line[31:24];
        endcase
        w_half = w_off[1] ? w_line[31:16] : w_line[15:0];
        case (mask)
            3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_load_data = {24'b0, w_byte};
            3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
            3'b101:  w_load_data = {16'b0, w_half};
            default: w_load_data = w_line;
        endcase
    end

    // Store data is replicated across lanes so memory and the line merge both pick bytes by enable.
    always_comb begin
        case (mask[1:0])
            2'b00: begin
                w_st_be    = 4'b0001 << w_off;
                w_st_wdata = {4{data_in[7:0]}};
            end
            2'b01: begin
                w_st_be    = w_off[1] ? 4'b1100 : 4'b0011;
                w_st_wdata = {2{data_in[15:0]}};
            end
            default: begin
                w_st_be    = 4'b1111;
                w_st_wdata = data_in;
            end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_merge
            assign w_merged[8*gi +: 8] = r_mem_be[gi] ? r_mem_wdata[8*gi +: 8] : w_line[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        stall        = 1'b0;
        data_out     = 32'b0;
        w_start_rd   = 1'b0;
        w_start_wr   = 1'b0;
        w_fill       = 1'b0;
        w_merge      = 1'b0;
        w_done       = 1'b0;
        w_hit_inc    = 1'b0;
        w_miss_inc   = 1'b0;
        w_clr_refill = 1'b0;
        w_flush      = 1'b0;
        case (r_state)
            IDLE: begin
                w_flush = flush;
                if ((w_is_load || w_is_store) && !w_bad_size) begin
                    if (flush) begin
                        stall = 1'b1;
                    end else if (w_is_load) begin
                        if (w_hit) begin
                            data_out     = w_load_data;
                            w_hit_inc    = !r_refill_done;
                            w_clr_refill = 1'b1;
                        end else begin
                            stall        = 1'b1;
                            w_miss_inc   = 1'b1;
                            w_start_rd   = 1'b1;
                            w_state_next = RD_MISS;
                        end
                    end else begin
                        stall        = 1'b1;
                        w_start_wr   = 1'b1;
                        w_state_next = WR_THRU;
                    end
                end
            end
            RD_MISS: begin
                stall = 1'b1;
                if (mem_ack) begin
                    w_fill       = 1'b1;
                    w_done       = 1'b1;
                    w_state_next = IDLE;
                end
            end
            WR_THRU: begin
                stall = !mem_ack;
                if (mem_ack) begin
                    w_merge      = w_hit;
                    w_done       = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_valid       <= '0;
            r_refill_done <= 1'b0;
            r_mem_req     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_mem_be      <= '0;
            r_hit_cnt     <= '0;
            r_miss_cnt    <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_flush)
                r_valid <= '0;
            else if (w_fill)
                r_valid[w_index] <= 1'b1;
            if (w_fill)
                r_refill_done <= 1'b1;
            else if (w_clr_refill)
                r_refill_done <= 1'b0;
            if (w_start_rd || w_start_wr) begin
                r_mem_req  <= 1'b1;
                r_mem_we   <= w_start_wr;
                r_mem_addr <= {address_in[ADDR_W-1:2], 2'b00};
            end else if (w_done) begin
                r_mem_req <= 1'b0;
                r_mem_we  <= 1'b0;
            end
            if (w_start_wr) begin
                r_mem_wdata <= w_st_wdata;
                r_mem_be    <= w_st_be;
            end
            if (w_hit_inc && r_hit_cnt != {CNT_W{1'b1}})
                r_hit_cnt <= r_hit_cnt + 1'b1;
            if (w_miss_inc && r_miss_cnt != {CNT_W{1'b1}})
                r_miss_cnt <= r_miss_cnt + 1'b1;
        end
    end

    // Tag/data arrays carry no reset; the valid vector alone decides whether a line is live.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (w_fill) begin
                r_tag[w_index]  <= w_tag;
                r_line[w_index] <= mem_rdata;
            end else if (w_merge) begin
                r_line[w_index] <= w_merged;
            end
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_be    = r_mem_be;
    assign hit_cnt   = r_hit_cnt;
    assign miss_cnt  = r_miss_cnt;
endmodule

// File: tb/tb_l1_dcache_dm.sv
// Self-checking bench for l1_dcache_dm: table of load/store vectors with a scoreboard queue,
// a latency-programmable memory responder, and a hand sequence for reset during a refill.
module tb_l1_dcache_dm;
    localparam int ADDR_W = 10;
    localparam int INDEX_W = 6;
    localparam int CNT_W = 16;
    localparam logic [6:0] LD  = 7'b0000011;
    localparam logic [6:0] ST  = 7'b0100011;
    localparam logic [6:0] NOP = 7'b0010011;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic [6:0]        opcode_in;
    logic [2:0]        mask;
    logic [ADDR_W-1:0] address_in;
    logic [31:0]       data_in;
    logic              flush;
    logic [31:0]       data_out;
    logic              stall, misalign;
    logic              mem_req, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_be;
    logic              mem_ack;
    logic [31:0]       mem_rdata;
    logic [CNT_W-1:0]  hit_cnt, miss_cnt;

    l1_dcache_dm #(.ADDR_W(ADDR_W), .INDEX_W(INDEX_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .opcode_in(opcode_in), .mask(mask),
        .address_in(address_in), .data_in(data_in), .flush(flush),
        .data_out(data_out), .stall(stall), .misalign(misalign),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    typedef struct {
        string       name;
        logic [6:0]  op;
        logic [2:0]  mask;
        logic [9:0]  addr;
        logic [31:0] din;
        bit          flush;
        int          lat;
        logic [31:0] exp_data;
        int          exp_stall;
        int          exp_req;
        bit          exp_mis;
        int          exp_hit;
        int          exp_miss;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
    } vec_t;

    int checks = 0;
    int errors = 0;
    vec_t sb_q[$];
    vec_t vecs[24];

    // Memory responder state (written only by the responder process)
    logic [31:0] mem_model [256];
    int          req_cnt;
    int          stable_viol;
    logic [9:0]  f_addr, last_addr;
    logic [31:0] f_wdata, last_wdata;
    logic [3:0]  f_be, last_be;
    logic        f_we;
    // Responder controls (written only by the main process)
    int          cur_lat;
    bit          auto_ack;
    bit          manual_ack;

    initial begin : responder
        for (int i = 0; i < 256; i++) mem_model[i] = 32'h0;
        mem_model[1]  = 32'hDEADBEEF;
        mem_model[17] = 32'hCAFEF00D;
        mem_ack = 1'b0; mem_rdata = 32'h0; req_cnt = 0; stable_viol = 0;
        f_addr = '0; f_wdata = '0; f_be = '0; f_we = 1'b0;
        last_addr = '0; last_wdata = '0; last_be = '0;
        forever begin
            @(posedge clk);
            #2;
            if (reset || !mem_req) begin
                req_cnt   = 0;
                mem_ack   = manual_ack;
                mem_rdata = manual_ack ? 32'h12345678 : 32'h0;
            end else begin
                if (req_cnt == 0) begin
                    f_addr = mem_addr; f_wdata = mem_wdata; f_be = mem_be; f_we = mem_we;
                end else if (mem_addr !== f_addr || mem_wdata !== f_wdata || mem_be !== f_be || mem_we !== f_we) begin
                    stable_viol++;
                end
                req_cnt++;
                last_addr = mem_addr; last_wdata = mem_wdata; last_be = mem_be;
                if (auto_ack && req_cnt == cur_lat) begin
                    mem_ack = 1'b1;
                    if (mem_we) begin
                        for (int b = 0; b < 4; b++)
                            if (mem_be[b]) mem_model[mem_addr[9:2]][8*b +: 8] = mem_wdata[8*b +: 8];
                        mem_rdata = 32'h0;
                    end else begin
                        mem_rdata = mem_model[mem_addr[9:2]];
                    end
                end else begin
                    mem_ack   = manual_ack;
                    mem_rdata = 32'h0;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input string nm, input logic [6:0] op, input logic [2:0] mk_mask,
                                input logic [9:0] a, input logic [31:0] din, input bit fl, input int lat,
                                input logic [31:0] ed, input int es, input int er, input bit em,
                                input int eh, input int emi, input logic [3:0] ebe, input logic [31:0] ewd);
        vec_t v;
        v.name = nm; v.op = op; v.mask = mk_mask; v.addr = a; v.din = din; v.flush = fl; v.lat = lat;
        v.exp_data = ed; v.exp_stall = es; v.exp_req = er; v.exp_mis = em;
        v.exp_hit = eh; v.exp_miss = emi; v.exp_be = ebe; v.exp_wdata = ewd;
        return v;
    endfunction

    // Called at posedge+1; drives one op, follows it to completion, returns at posedge+1 with a no-op driven.
    task automatic apply(input vec_t v);
        vec_t        e;
        int          st, rq, viol0;
        logic [31:0] d;
        logic        mis;
        bit          done;
        sb_q.push_back(v);
        viol0 = stable_viol;
        cur_lat = v.lat;
        opcode_in = v.op; mask = v.mask; address_in = v.addr; data_in = v.din; flush = v.flush;
        st = 0; rq = 0; done = 0; d = 32'h0; mis = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (mem_req) rq++;
            if (stall) begin
                st++;
                @(posedge clk);
                #1;
                flush = 1'b0;
            end else begin
                d = data_out; mis = misalign; done = 1;
            end
        end
        @(posedge clk);
        #1;
        opcode_in = NOP; flush = 1'b0; data_in = 32'h0;
        e = sb_q.pop_front();
        chk({e.name, " completes"}, {31'b0, done}, 32'd1);
        chk({e.name, " data_out"}, d, e.exp_data);
        chk({e.name, " stall_cycles"}, st, e.exp_stall);
        chk({e.name, " req_cycles"}, rq, e.exp_req);
        chk({e.name, " misalign"}, {31'b0, mis}, {31'b0, e.exp_mis});
        chk({e.name, " hit_cnt"}, {16'b0, hit_cnt}, e.exp_hit);
        chk({e.name, " miss_cnt"}, {16'b0, miss_cnt}, e.exp_miss);
        chk({e.name, " req_stable"}, stable_viol - viol0, 32'd0);
        if (e.exp_req > 0)
            chk({e.name, " mem_addr"}, {22'b0, last_addr}, {22'b0, e.addr[9:2], 2'b00});
        if (e.op == ST && e.exp_req > 0) begin
            chk({e.name, " mem_be"}, {28'b0, last_be}, {28'b0, e.exp_be});
            chk({e.name, " mem_wdata"}, last_wdata, e.exp_wdata);
        end
        $display("txn %-14s addr=%h data_out=%h stall=%0d req=%0d mis=%0d hit=%0d miss=%0d",
                 e.name, e.addr, d, st, rq, mis, hit_cnt, miss_cnt);
    endtask

    initial begin
        reset = 1'b1; opcode_in = NOP; mask = 3'b010; address_in = '0; data_in = '0; flush = 1'b0;
        auto_ack = 1'b1; manual_ack = 1'b0; cur_lat = 1;

        //            name            op   mask    addr    din          fl lat exp_data      st rq mis hit miss be     wdata
        vecs[0]  = mk("LW cold",      LD, 3'b010, 10'h004, 32'h0,        0, 3, 32'hDEADBEEF, 4, 3, 0, 0,  1, 4'h0, 32'h0);
        vecs[1]  = mk("LW warm",      LD, 3'b010, 10'h004, 32'h0,        0, 1, 32'hDEADBEEF, 0, 0, 0, 1,  1, 4'h0, 32'h0);
        vecs[2]  = mk("SW 004",       ST, 3'b010, 10'h004, 32'h80FF7F01, 0, 2, 32'h0,        2, 2, 0, 1,  1, 4'hF, 32'h80FF7F01);
        vecs[3]  = mk("LW 004",       LD, 3'b010, 10'h004, 32'h0,        0, 1, 32'h80FF7F01, 0, 0, 0, 2,  1, 4'h0, 32'h0);
        vecs[4]  = mk("LB 007",       LD, 3'b000, 10'h007, 32'h0,        0, 1, 32'hFFFFFF80, 0, 0, 0, 3,  1, 4'h0, 32'h0);
        vecs[5]  = mk("LBU 007",      LD, 3'b100, 10'h007, 32'h0,        0, 1, 32'h00000080, 0, 0, 0, 4,  1, 4'h0, 32'h0);
        vecs[6]  = mk("LH 004",       LD, 3'b001, 10'h004, 32'h0,        0, 1, 32'h00007F01, 0, 0, 0, 5,  1, 4'h0, 32'h0);
        vecs[7]  = mk("LHU 006",      LD, 3'b101, 10'h006, 32'h0,        0, 1, 32'h000080FF, 0, 0, 0, 6,  1, 4'h0, 32'h0);
        vecs[8]  = mk("SB 005",       ST, 3'b000, 10'h005, 32'h000000AB, 0, 1, 32'h0,        1, 1, 0, 6,  1, 4'h2, 32'hABABABAB);
        vecs[9]  = mk("LW merged",    LD, 3'b010, 10'h004, 32'h0,        0, 1, 32'h80FFAB01, 0, 0, 0, 7,  1, 4'h0, 32'h0);
        vecs[10] = mk("SW 104 alias", ST, 3'b010, 10'h104, 32'h11223344, 0, 1, 32'h0,        1, 1, 0, 7,  1, 4'hF, 32'h11223344);
        vecs[11] = mk("LW 004 kept",  LD, 3'b010, 10'h004, 32'h0,        0, 1, 32'h80FFAB01, 0, 0, 0, 8,  1, 4'h0, 32'h0);
        vecs[12] = mk("LW 104 miss",  LD, 3'b010, 10'h104, 32'h0,        0, 2, 32'h11223344, 3, 2, 0, 8,  2, 4'h0, 32'h0);
        vecs[13] = mk("LW 004 remiss",LD, 3'b010, 10'h004, 32'h0,        0, 1, 32'h80FFAB01, 2, 1, 0, 8,  3, 4'h0, 32'h0);
        vecs[14] = mk("LH 005 mis",   LD, 3'b001, 10'h005, 32'h0,        0, 1, 32'h0,        0, 0, 1, 8,  3, 4'h0, 32'h0);
        vecs[15] = mk("LW 002 mis",   LD, 3'b010, 10'h002, 32'h0,        0, 1, 32'h0,        0, 0, 1, 8,  3, 4'h0, 32'h0);
        vecs[16] = mk("f3=011 mis",   LD, 3'b011, 10'h000, 32'h0,        0, 1, 32'h0,        0, 0, 1, 8,  3, 4'h0, 32'h0);
        vecs[17] = mk("SH 003 mis",   ST, 3'b001, 10'h003, 32'h5555,     0, 1, 32'h0,        0, 0, 1, 8,  3, 4'h0, 32'h0);
        vecs[18] = mk("no-op",        NOP,3'b010, 10'h004, 32'h0,        0, 1, 32'h0,        0, 0, 0, 8,  3, 4'h0, 32'h0);
        vecs[19] = mk("LBU 004",      LD, 3'b100, 10'h004, 32'h0,        0, 1, 32'h00000001, 0, 0, 0, 9,  3, 4'h0, 32'h0);
        vecs[20] = mk("LH 006",       LD, 3'b001, 10'h006, 32'h0,        0, 1, 32'hFFFF80FF, 0, 0, 0, 10, 3, 4'h0, 32'h0);
        vecs[21] = mk("SH 006",       ST, 3'b001, 10'h006, 32'h0000BEEF, 0, 3, 32'h0,        3, 3, 0, 10, 3, 4'hC, 32'hBEEFBEEF);
        vecs[22] = mk("flush+LW 004", LD, 3'b010, 10'h004, 32'h0,        1, 1, 32'hBEEFAB01, 3, 1, 0, 10, 4, 4'h0, 32'h0);
        vecs[23] = mk("LW 004 after", LD, 3'b010, 10'h004, 32'h0,        0, 1, 32'hBEEFAB01, 0, 0, 0, 11, 4, 4'h0, 32'h0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst stall", {31'b0, stall}, 32'd0);
        chk("rst data_out", data_out, 32'h0);
        chk("rst misalign", {31'b0, misalign}, 32'd0);
        chk("rst mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst mem_we", {31'b0, mem_we}, 32'd0);
        chk("rst mem_addr", {22'b0, mem_addr}, 32'h0);
        chk("rst mem_wdata", mem_wdata, 32'h0);
        chk("rst mem_be", {28'b0, mem_be}, 32'h0);
        chk("rst hit_cnt", {16'b0, hit_cnt}, 32'h0);
        chk("rst miss_cnt", {16'b0, miss_cnt}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 24; i++) apply(vecs[i]);

        // Reset two cycles into a refill, then a stray ack one cycle later.
        auto_ack = 1'b0;
        opcode_in = LD; mask = 3'b010; address_in = 10'h044;
        @(posedge clk);
        #1;
        chk("midrst req_up", {31'b0, mem_req}, 32'd1);
        @(posedge clk);
        #1;
        chk("midrst still_stall", {31'b0, stall}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0; opcode_in = NOP; manual_ack = 1'b1;
        @(posedge clk);
        #1;
        manual_ack = 1'b0; auto_ack = 1'b1;
        chk("midrst mem_req", {31'b0, mem_req}, 32'd0);
        chk("midrst mem_we", {31'b0, mem_we}, 32'd0);
        chk("midrst mem_addr", {22'b0, mem_addr}, 32'h0);
        chk("midrst hit_cnt", {16'b0, hit_cnt}, 32'h0);
        chk("midrst miss_cnt", {16'b0, miss_cnt}, 32'h0);
        $display("txn midrst        reset during RD_MISS, stray ack issued");
        apply(mk("LW 044 postrst", LD, 3'b010, 10'h044, 32'h0, 0, 2, 32'hCAFEF00D, 3, 2, 0, 0, 1, 4'h0, 32'h0));
        apply(mk("LW 044 hit",     LD, 3'b010, 10'h044, 32'h0, 0, 1, 32'hCAFEF00D, 0, 0, 0, 1, 1, 4'h0, 32'h0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
